// File: rtl/fusion_sched_pkg.sv
// fusion_sched_pkg: opcodes, source ids and FSM states shared by the scheduler and its bench
package fusion_sched_pkg;
    localparam logic OP_UPDATE = 1'b0;
    localparam logic OP_PREDICT = 1'b1;
    localparam logic [1:0] SRC_CAM = 2'd0;
    localparam logic [1:0] SRC_LIDAR = 2'd1;
    localparam logic [1:0] SRC_RADAR = 2'd2;
    localparam logic [1:0] SRC_IMU = 2'd3;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;
endpackage

// File: rtl/fusion_measurement_scheduler_if.sv
// fusion_measurement_scheduler_if: source capture and engine command/done signals
interface fusion_measurement_scheduler_if #(parameter int N_SRC = 4, parameter int DATA_W = 64);
    localparam int SW = $clog2(N_SRC);
    logic [N_SRC-1:0] src_valid;
    logic [N_SRC-1:0] src_ready;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic eng_cmd_valid;
    logic eng_cmd_ready;
    logic eng_cmd_op;
    logic [SW-1:0] eng_cmd_src;
    logic [DATA_W-1:0] eng_cmd_data;
    logic eng_done;
    modport master (
        input src_valid, src_data, eng_cmd_ready, eng_done,
        output src_ready, eng_cmd_valid, eng_cmd_op, eng_cmd_src, eng_cmd_data
    );
    modport slave (
        output src_valid, src_data, eng_cmd_ready, eng_done,
        input src_ready, eng_cmd_valid, eng_cmd_op, eng_cmd_src, eng_cmd_data
    );
endinterface

// File: rtl/fusion_rr_arbiter.sv
// fusion_rr_arbiter: combinational round-robin pick, searching upward from ptr+1 with wrap
module fusion_rr_arbiter #(parameter int N = 4, localparam int W = $clog2(N)) (
    input logic [N-1:0] req,
    input logic [W-1:0] ptr,
    output logic [W-1:0] gnt,
    output logic req_any
);
    always_comb begin
        gnt = ptr;
        req_any = 1'b0;
        // walk from farthest to nearest so the nearest requester after ptr wins
        for (int k = N; k >= 1; k--) begin
            if (req[W'((int'(ptr) + k) % N)]) begin
                gnt = W'((int'(ptr) + k) % N);
                req_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/fusion_measurement_scheduler.sv
// fusion_measurement_scheduler: one-packet-per-source holding, periodic predict pre-emption,
// round-robin update grants and a watchdog on the Kalman engine
module fusion_measurement_scheduler import fusion_sched_pkg::*; #(
    parameter int N_SRC = 4,
    parameter int DATA_W = 64,
    parameter int PREDICT_PERIOD = 1000,
    parameter int TIMEOUT = 256
) (
    input logic clk_200mhz,
    input logic rst,
    fusion_measurement_scheduler_if.master bus,
    output logic busy,
    output logic timeout_err,
    output logic predict_missed
);
    localparam int SW = $clog2(N_SRC);
    localparam int TW = $clog2(PREDICT_PERIOD);
    localparam int WW = $clog2(TIMEOUT);
    state_t state;
    logic [N_SRC-1:0] pend;
    logic [DATA_W-1:0] pend_data [N_SRC];
    logic predict_pend;
    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] gnt;
    logic req_any;
    logic [TW-1:0] timer;
    logic [WW-1:0] wd;
    logic tick;
    logic take_predict;
    fusion_rr_arbiter #(.N(N_SRC)) u_arb (.req(pend), .ptr(rr_ptr), .gnt(gnt), .req_any(req_any));
    assign bus.src_ready = ~pend;
    assign tick = timer == TW'(PREDICT_PERIOD - 1);
    assign take_predict = state == ISSUE && bus.eng_cmd_ready && bus.eng_cmd_op;
    always_ff @(posedge clk_200mhz or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            pend <= '0;
            for (int i = 0; i < N_SRC; i++) pend_data[i] <= '0;
            predict_pend <= 1'b0;
            rr_ptr <= SW'(N_SRC - 1);
            timer <= '0;
            wd <= '0;
            bus.eng_cmd_valid <= 1'b0;
            bus.eng_cmd_op <= OP_UPDATE;
            bus.eng_cmd_src <= '0;
            bus.eng_cmd_data <= '0;
            busy <= 1'b0;
            timeout_err <= 1'b0;
            predict_missed <= 1'b0;
        end else begin
            timer <= tick ? '0 : timer + 1'b1;
            timeout_err <= 1'b0;
            // a tick landing on the accept of the pending predict re-arms it rather than being lost
            predict_missed <= tick && predict_pend && !take_predict;
            for (int i = 0; i < N_SRC; i++) begin
                if (bus.src_valid[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                    pend_data[i] <= bus.src_data[i*DATA_W +: DATA_W];
                end
            end
            case (state)
                IDLE: begin
                    if (predict_pend || req_any) begin
                        state <= ISSUE;
                        busy <= 1'b1;
                        bus.eng_cmd_valid <= 1'b1;
                        bus.eng_cmd_op <= predict_pend ? OP_PREDICT : OP_UPDATE;
                        bus.eng_cmd_src <= predict_pend ? '0 : gnt;
                        bus.eng_cmd_data <= predict_pend ? '0 : pend_data[gnt];
                    end
                end
                ISSUE: begin
                    if (bus.eng_cmd_ready) begin
                        state <= WAIT_DONE;
                        bus.eng_cmd_valid <= 1'b0;
                        wd <= '0;
                        if (bus.eng_cmd_op) begin
                            predict_pend <= 1'b0;
                        end else begin
                            pend[bus.eng_cmd_src] <= 1'b0;
                            rr_ptr <= bus.eng_cmd_src;
                        end
                    end
                end
                WAIT_DONE: begin
                    wd <= wd + 1'b1;
                    if (bus.eng_done || wd == WW'(TIMEOUT - 1)) begin
                        state <= IDLE;
                        busy <= 1'b0;
                        timeout_err <= !bus.eng_done;
                    end
                end
                default: state <= IDLE;
            endcase
            if (tick) predict_pend <= 1'b1;
        end
    end
endmodule

// File: doc/fusion_measurement_scheduler.md
# fusion_measurement_scheduler

Sequences the shared Kalman update engine of the sensor-fusion pipeline. It accepts measurement packets from four front-ends (camera detector, LiDAR processor, radar, IMU), holds one packet per source, and issues one command at a time to the engine. A periodic PREDICT command pre-empts queued updates; any UPDATE is granted round-robin among the sources.

## Interface
- N_SRC, 4: number of measurement sources. Index 0 camera, 1 LiDAR, 2 radar, 3 IMU.
- DATA_W, 64: measurement payload width.
- PREDICT_PERIOD, 1000: cycles between predict ticks (≥4).
- TIMEOUT, 256: maximum number of WAIT_DONE cycles before abort.
- clk_200mhz  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- src_valid  in  N_SRC  per-source packet valid.
- src_data  in  N_SRC*DATA_W  packets; source i occupies bits [i*DATA_W +: DATA_W].
- src_ready  out  N_SRC  per-source ready; equals ~pend[i].
- eng_cmd_valid  out  1  command valid to engine.
- eng_cmd_ready  in  1  engine accepts command.
- eng_cmd_op  out  1  0 = UPDATE, 1 = PREDICT.
- eng_cmd_src  out  2  source index. 0 for PREDICT.
- eng_cmd_data  out  DATA_W  payload. 0 for PREDICT.
- eng_done  in  1  single-cycle completion pulse from engine.
- busy  out  1  high in ISSUE or WAIT_DONE.
- timeout_err  out  1  single-cycle pulse on watchdog abort.
- predict_missed  out  1  single-cycle pulse when a tick arrives while a predict is still pending.

## Operation
- Capture: a packet is taken when src_valid[i] && src_ready[i]. The data goes into pend_data[i] and pend[i] is set. There is no other buffering.
- Predict timer: a free-running counter counts 0..PREDICT_PERIOD-1. At the terminal count it sets predict_pend. If predict_pend is already set, it pulses predict_missed and the tick is not accumulated.
- States:
  - IDLE → ISSUE when predict_pend or any pend[i] is set.
  - ISSUE → WAIT_DONE on eng_cmd_valid && eng_cmd_ready.
  - WAIT_DONE → IDLE on eng_done, or when the watchdog reaches TIMEOUT.
- Arbitration happens in IDLE only:
  - predict_pend wins over all sources.
  - Otherwise, round-robin over pend[], searching from rr_ptr+1 upward with wrap.
  - The winner's command fields are registered on the IDLE→ISSUE edge.
- ISSUE:
  - eng_cmd_valid is held high.
  - op, src and data stay stable until the handshake.
  - On the handshake, clear the winner's pend[i] (or predict_pend). rr_ptr is set to the winner only for UPDATE grants.
- Simultaneous events:
  - A predict tick on the same edge as the predict_pend clear: set wins, and predict_pend stays 1.
  - A source's capture cannot coincide with its own clear, because src_ready is low while pend is set.
- WAIT_DONE:
  - The watchdog counts from 0 each cycle.
  - If count == TIMEOUT-1 without eng_done, pulse timeout_err and go to IDLE. The aborted command is not retried.
- eng_done outside WAIT_DONE is ignored.
- eng_cmd_ready outside ISSUE is ignored.

## Timing
- Reset values:
  - Outputs: src_ready all 1s, eng_cmd_valid 0, eng_cmd_op 0, eng_cmd_src 0, eng_cmd_data 0, busy 0, timeout_err 0, predict_missed 0.
  - Internal: state IDLE, rr_ptr N_SRC-1, timer 0, all pend flags clear.
- Reset asserted mid-operation aborts immediately. Pending packets are discarded.
- All outputs are registered except src_ready, which is combinational from the pend flags.
- Capture at edge t makes the source eligible in IDLE at t+1.
- Latency: pending in IDLE at cycle t → eng_cmd_valid high at t+1.
- Ready: src_ready falls at t+1 after capture, and rises the cycle after the grant handshake.
- Throughput: at most one command per 3 cycles (IDLE, ISSUE with ready, WAIT_DONE with done).
- The first predict tick occurs PREDICT_PERIOD cycles after reset release.

## Structure
- Shared package fusion_sched_pkg holds:
  - OP_UPDATE = 0, OP_PREDICT = 1.
  - SRC_CAM/SRC_LIDAR/SRC_RADAR/SRC_IMU = 0..3.
  - The state enum: IDLE, ISSUE, WAIT_DONE.
- Sub-module fusion_rr_arbiter (N-way round-robin, combinational grant from req and rr_ptr) is instantiated once.

## Test plan
- Reset release with no stimulus, 999 cycles → no command. Cycle 1000 → PREDICT issued with src 0 and data 0.
- Packets on sources 1, 2, 3 in the same cycle with rr_ptr = 3 → grants in order 1, 2, 3 when the engine returns done 2 cycles after each accept.
- A camera packet is pending when a predict tick fires → PREDICT is issued first and the camera UPDATE follows.
- Engine holds eng_cmd_ready low for 10 cycles → eng_cmd_valid and all fields stay stable, and src_ready[i] stays 0.
- Engine never asserts eng_done → timeout_err pulses after 256 WAIT_DONE cycles, then the FSM returns to IDLE and serves the next source.
- Engine stalls across two predict ticks → predict_missed pulses once. rst asserted in WAIT_DONE → all outputs return to their reset values asynchronously.
